rtc_timekeeper: RTL and testbench

Parametrised time-of-day counter: prescales the system clock to a 1 Hz tick and advances cascaded seconds/minutes/hours counters. It adds run/stop, synchronous time load with range checking, an optional 12-hour output format, a day-rollover pulse and a compile-time alarm comparator. It sits beside the existing timer blocks as the next-generation clock source for status/display logic.

---
 rtl/rtc_timekeeper_if.sv | 34 +++
 rtl/rtc_timekeeper.sv | 169 ++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_timekeeper_if.sv
// Bus bundle for rtc_timekeeper: run/load controls in, time-of-day and pulses out.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_timekeeper_if;
    logic       en;
    logic       load;
    logic [4:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       pm;
    logic       sec_tick;
    logic       day_tc;
    logic       load_err;
`ifdef RTC_ALARM_EN
    logic       al_wr;
    logic [4:0] al_hr;
    logic [5:0] al_min;
    logic [5:0] al_sec;
    logic       alarm_clr;
    logic       alarm;

    modport master (output en, load, ld_hr, ld_min, ld_sec, al_wr, al_hr, al_min, al_sec, alarm_clr,
                    input  sec, min, hr, pm, sec_tick, day_tc, load_err, alarm);
    modport slave  (input  en, load, ld_hr, ld_min, ld_sec, al_wr, al_hr, al_min, al_sec, alarm_clr,
                    output sec, min, hr, pm, sec_tick, day_tc, load_err, alarm);
`else
    modport master (output en, load, ld_hr, ld_min, ld_sec,
                    input  sec, min, hr, pm, sec_tick, day_tc, load_err);
    modport slave  (input  en, load, ld_hr, ld_min, ld_sec,
                    output sec, min, hr, pm, sec_tick, day_tc, load_err);
`endif
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: 1 Hz prescaler feeding binary sec/min/hour counters with load,
// optional 12-hour output and a sticky alarm comparator enabled by RTC_ALARM_EN.
module rtc_timekeeper #(
    parameter int CLK_HZ = 1_000_000,
    parameter int PRE_W  = 20,
    parameter int HR12   = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    rtc_timekeeper_if.slave bus
);

    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_HZ - 1);
    localparam logic [4:0]       HR_RESET = (HR12 != 0) ? 5'd12 : 5'd0;

    function automatic logic time_ok(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
    endfunction

    // 24-hour value to displayed hour; 0 and 12 both show as 12 in 12-hour mode
    function automatic logic [4:0] hr_fmt(input logic [4:0] h);
        logic [4:0] r;
        if (HR12 == 0) begin
            r = h;
        end else if (h == 5'd0) begin
            r = 5'd12;
        end else if (h > 5'd12) begin
            r = h - 5'd12;
        end else begin
            r = h;
        end
        return r;
    endfunction

    logic [PRE_W-1:0] pre_r, pre_nxt_s;
    logic [5:0]       sec_r, sec_nxt_s;
    logic [5:0]       min_r, min_nxt_s;
    logic [4:0]       h24_r, h24_nxt_s;
    logic [4:0]       hr_r;
    logic             pm_r;
    logic             tick_r, tick_nxt_s;
    logic             day_r, day_nxt_s;
    logic             err_r, err_nxt_s;

    // Next time/prescaler: a load (valid or not) takes precedence over any tick
    always_comb begin
        pre_nxt_s  = pre_r;
        sec_nxt_s  = sec_r;
        min_nxt_s  = min_r;
        h24_nxt_s  = h24_r;
        tick_nxt_s = 1'b0;
        day_nxt_s  = 1'b0;
        err_nxt_s  = 1'b0;
        if (bus.load) begin
            if (time_ok(bus.ld_hr, bus.ld_min, bus.ld_sec)) begin
                pre_nxt_s = '0;
                sec_nxt_s = bus.ld_sec;
                min_nxt_s = bus.ld_min;
                h24_nxt_s = bus.ld_hr;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else if (bus.en) begin
            if (pre_r == PRE_TC) begin
                pre_nxt_s  = '0;
                tick_nxt_s = 1'b1;
                if (sec_r == 6'd59) begin
                    sec_nxt_s = 6'd0;
                    if (min_r == 6'd59) begin
                        min_nxt_s = 6'd0;
                        if (h24_r == 5'd23) begin
                            h24_nxt_s = 5'd0;
                            day_nxt_s = 1'b1;
                        end else begin
                            h24_nxt_s = h24_r + 5'd1;
                        end
                    end else begin
                        min_nxt_s = min_r + 6'd1;
                    end
                end else begin
                    sec_nxt_s = sec_r + 6'd1;
                end
            end else begin
                pre_nxt_s = pre_r + PRE_W'(1);
            end
        end else begin
            pre_nxt_s = pre_r;
        end
    end

    // Time state and registered outputs; hr/pm derive from the next hour so they align with sec/min
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_r  <= '0;
            sec_r  <= 6'd0;
            min_r  <= 6'd0;
            h24_r  <= 5'd0;
            hr_r   <= HR_RESET;
            pm_r   <= 1'b0;
            tick_r <= 1'b0;
            day_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            pre_r  <= pre_nxt_s;
            sec_r  <= sec_nxt_s;
            min_r  <= min_nxt_s;
            h24_r  <= h24_nxt_s;
            hr_r   <= hr_fmt(h24_nxt_s);
            pm_r   <= (h24_nxt_s >= 5'd12);
            tick_r <= tick_nxt_s;
            day_r  <= day_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign bus.sec      = sec_r;
    assign bus.min      = min_r;
    assign bus.hr       = hr_r;
    assign bus.pm       = pm_r;
    assign bus.sec_tick = tick_r;
    assign bus.day_tc   = day_r;
    assign bus.load_err = err_r;

`ifdef RTC_ALARM_EN
    logic [4:0] al_hr_r;
    logic [5:0] al_min_r;
    logic [5:0] al_sec_r;
    logic       armed_r;
    logic       alarm_r, alarm_nxt_s;
    logic       al_set_s;

    // Match only on a tick-driven advance, never on a load; set beats clear
    always_comb begin
        al_set_s = tick_nxt_s && armed_r && (sec_nxt_s == al_sec_r)
                   && (min_nxt_s == al_min_r) && (h24_nxt_s == al_hr_r);
        if (al_set_s) begin
            alarm_nxt_s = 1'b1;
        end else if (bus.alarm_clr) begin
            alarm_nxt_s = 1'b0;
        end else begin
            alarm_nxt_s = alarm_r;
        end
    end

    // Alarm time capture (out-of-range writes dropped) and sticky flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hr_r  <= 5'd0;
            al_min_r <= 6'd0;
            al_sec_r <= 6'd0;
            armed_r  <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            if (bus.al_wr && time_ok(bus.al_hr, bus.al_min, bus.al_sec)) begin
                al_hr_r  <= bus.al_hr;
                al_min_r <= bus.al_min;
                al_sec_r <= bus.al_sec;
                armed_r  <= 1'b1;
            end else begin
                armed_r  <= armed_r;
            end
            alarm_r <= alarm_nxt_s;
        end
    end

    assign bus.alarm = alarm_r;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized bench for rtc_timekeeper: a 24-hour and a 12-hour instance share stimulus and are
// checked against a seconds-of-day model; alarm checks compile in with RTC_ALARM_EN.
module tb_rtc_timekeeper;
    localparam int CLK_HZ = 4;
    localparam int PRE_W  = 3;
    localparam int DAY    = 86400;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    rtc_timekeeper_if b24 ();
    rtc_timekeeper_if b12 ();

    rtc_timekeeper #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W), .HR12(0)) u24 (.clk(clk), .reset_n(reset_n), .bus(b24.slave));
    rtc_timekeeper #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W), .HR12(1)) u12 (.clk(clk), .reset_n(reset_n), .bus(b12.slave));

    assign b12.en     = b24.en;
    assign b12.load   = b24.load;
    assign b12.ld_hr  = b24.ld_hr;
    assign b12.ld_min = b24.ld_min;
    assign b12.ld_sec = b24.ld_sec;
`ifdef RTC_ALARM_EN
    assign b12.al_wr     = b24.al_wr;
    assign b12.al_hr     = b24.al_hr;
    assign b12.al_min    = b24.al_min;
    assign b12.al_sec    = b24.al_sec;
    assign b12.alarm_clr = b24.alarm_clr;
`endif

    // reference model: time as seconds-of-day, phase counts cycles within the current second
    int tsec, phase, al_t;
    bit armed, alarm_e, tick_e, day_e, err_e;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        tsec = 0; phase = 0; al_t = 0;
        armed = 0; alarm_e = 0; tick_e = 0; day_e = 0; err_e = 0;
    endtask

    task automatic check_all();
        int h;
        h = tsec / 3600;
        check("sec", int'(b24.sec), tsec % 60);
        check("min", int'(b24.min), (tsec / 60) % 60);
        check("hr24", int'(b24.hr), h);
        check("hr12", int'(b12.hr), (h % 12 == 0) ? 12 : h % 12);
        check("pm24", int'(b24.pm), int'(h >= 12));
        check("pm12", int'(b12.pm), int'(h >= 12));
        check("sec12", int'(b12.sec), tsec % 60);
        check("sec_tick", int'(b24.sec_tick), int'(tick_e));
        check("day_tc", int'(b24.day_tc), int'(day_e));
        check("load_err", int'(b24.load_err), int'(err_e));
`ifdef RTC_ALARM_EN
        check("alarm", int'(b24.alarm), int'(alarm_e));
`endif
    endtask

    // one clock: update the model from the inputs sampled at the edge, then check
    task automatic cycle();
        int lh, lm, ls, old_al;
        bit old_armed, set;
        @(posedge clk);
        tick_e = 0; day_e = 0; err_e = 0;
        old_al = al_t; old_armed = armed;
        lh = int'(b24.ld_hr); lm = int'(b24.ld_min); ls = int'(b24.ld_sec);
        if (b24.load) begin
            if (lh < 24 && lm < 60 && ls < 60) begin
                tsec = lh * 3600 + lm * 60 + ls;
                phase = 0;
            end else begin
                err_e = 1;
            end
        end else if (b24.en) begin
            if (phase == CLK_HZ - 1) begin
                phase = 0;
                tsec = (tsec + 1) % DAY;
                tick_e = 1;
                day_e = (tsec == 0);
            end else begin
                phase++;
            end
        end
`ifdef RTC_ALARM_EN
        set = tick_e && old_armed && (tsec == old_al);
        if (set) alarm_e = 1;
        else if (b24.alarm_clr) alarm_e = 0;
        if (b24.al_wr && b24.al_hr < 5'd24 && b24.al_min < 6'd60 && b24.al_sec < 6'd60) begin
            al_t = int'(b24.al_hr) * 3600 + int'(b24.al_min) * 60 + int'(b24.al_sec);
            armed = 1;
        end
`else
        set = old_armed;
        set = 0;
`endif
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic step(input bit e, input bit ld, input int h, input int m, input int s);
        b24.en = e;
        b24.load = ld;
        b24.ld_hr = 5'(h);
        b24.ld_min = 6'(m);
        b24.ld_sec = 6'(s);
        cycle();
        b24.load = 1'b0;
`ifdef RTC_ALARM_EN
        b24.al_wr = 1'b0;
        b24.alarm_clr = 1'b0;
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        b24.en = 1'b0; b24.load = 1'b0;
        b24.ld_hr = 5'd0; b24.ld_min = 6'd0; b24.ld_sec = 6'd0;
`ifdef RTC_ALARM_EN
        b24.al_wr = 1'b0; b24.al_hr = 5'd0; b24.al_min = 6'd0; b24.al_sec = 6'd0;
        b24.alarm_clr = 1'b0;
`endif
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // free run, then a pause mid-second that must hold the prescaler
        run(13);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 0);
        run(9);

        // day rollover
        step(1'b1, 1'b1, 23, 59, 58);
        run(10);

        // rejected loads leave time alone
        step(1'b1, 1'b1, 10, 60, 0);
        step(1'b1, 1'b1, 24, 0, 0);
        step(1'b0, 1'b1, 1, 2, 60);
        run(2);

        // valid load on the tick cycle discards the tick
        for (int i = 0; i < CLK_HZ && phase != CLK_HZ - 1; i++) step(1'b1, 1'b0, 0, 0, 0);
        check("phase_ready", phase, CLK_HZ - 1);
        step(1'b1, 1'b1, 5, 6, 7);
        run(5);

        // 12-hour formatting corners
        step(1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b1, 12, 30, 0);
        step(1'b0, 1'b1, 13, 0, 0);
        step(1'b0, 1'b1, 11, 59, 59);
        run(6);

`ifdef RTC_ALARM_EN
        b24.al_wr = 1'b1; b24.al_hr = 5'd0; b24.al_min = 6'd0; b24.al_sec = 6'd3;
        step(1'b0, 1'b1, 0, 0, 1);
        run(10);
        b24.alarm_clr = 1'b1;
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 0, 0, 3);
        step(1'b0, 1'b1, 0, 0, 2);
        for (int i = 0; i < CLK_HZ && phase != CLK_HZ - 1; i++) step(1'b1, 1'b0, 0, 0, 0);
        b24.alarm_clr = 1'b1;
        step(1'b1, 1'b0, 0, 0, 0);
        check("alarm_set_wins", int'(b24.alarm), 1);
        b24.al_wr = 1'b1; b24.al_hr = 5'd24; b24.al_min = 6'd0; b24.al_sec = 6'd0;
        step(1'b1, 1'b0, 0, 0, 0);
`endif

        // asynchronous reset between edges
        run(6);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        run(10);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
`ifdef RTC_ALARM_EN
            b24.al_wr = ($urandom % 32 == 0);
            b24.al_hr = 5'($urandom % 25);
            b24.al_min = 6'($urandom % 61);
            b24.al_sec = 6'($urandom % 61);
            b24.alarm_clr = ($urandom % 16 == 0);
`endif
            if ($urandom % 40 == 0)
                step(1'b1, 1'b1, 23, 59, 50 + int'($urandom % 10));
            else
                step(($urandom % 8) != 0, ($urandom % 20) == 0,
                     int'($urandom % 26), int'($urandom % 62), int'($urandom % 62));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
